alu_share_arbiter: RTL and testbench

- Shares the single 32-bit combinational ALU between two requesters, e.g. the EX stage (port 0) and a coprocessor/address-gen unit (port 1).
- Arbitrates round-robin and latches the winner's operands.
- Drives the ALU inputs for a sel-dependent number of cycles, giving multiply/divide a multicycle path.
- Returns the registered result on one shared response channel tagged with the requester ID.

---
 rtl/alu_share_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin share of one combinational 32-bit ALU
// between two valid/ready requesters. The winner's operands are latched and
// held on the ALU inputs for a sel-dependent number of cycles (multicycle
// mul/div), then the result is returned on a single tagged response channel.
// Optional build macro: ALU_ARB_DIV0_GUARD_EN (short-circuits divide by zero).
module alu_share_arbiter #(
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter int unsigned ALU_CYCLES    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [4:0]  req0_sel,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req1_sel,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_sel,
  input  logic [31:0] alu_out,
  input  logic        alu_carry,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_carry,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [4:0] SEL_MUL = 5'b00010;
  localparam logic [4:0] SEL_DIV = 5'b00011;

  // Counter preloads: cnt counts remaining extra EXEC cycles, so L-1.
  localparam logic [3:0] MULDIV_CNT = 4'(MULDIV_CYCLES - 1);
  localparam logic [3:0] ALU_CNT    = 4'(ALU_CYCLES - 1);

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [4:0]  alu_sel_q, alu_sel_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_carry_q, rsp_carry_d;
  logic        rsp_err_q, rsp_err_d;

  logic        grant_id;
  logic        xfer;
  logic [31:0] win_a;
  logic [31:0] win_b;
  logic [4:0]  win_sel;
  logic        div0;

  // Arbitration: single valid wins outright; contention goes to the port
  // that did not win last. Ready only in IDLE, only for the winner.
  always_comb begin
    grant_id   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else begin
      grant_id = req1_valid;
    end
    if ((state_q == IDLE) && !rst) begin
      req0_ready = req0_valid && !grant_id;
      req1_ready = req1_valid &&  grant_id;
    end
    xfer    = req0_ready || req1_ready;
    win_a   = grant_id ? req1_a   : req0_a;
    win_b   = grant_id ? req1_b   : req0_b;
    win_sel = grant_id ? req1_sel : req0_sel;
`ifdef ALU_ARB_DIV0_GUARD_EN
    div0 = (win_sel == SEL_DIV) && (win_b == '0);
`else
    div0 = 1'b0;
`endif
  end

  // Next-state and datapath updates for the IDLE/EXEC/RESP sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_err_d    = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          last_grant_d = grant_id;
          alu_a_d      = win_a;
          alu_b_d      = win_b;
          alu_sel_d    = win_sel;
          rsp_id_d     = grant_id;
          rsp_err_d    = div0;
          if ((win_sel == SEL_MUL) || (win_sel == SEL_DIV)) begin
            cnt_d = MULDIV_CNT;
          end else begin
            cnt_d = ALU_CNT;
          end
          if (div0) begin
            // Divide by zero bypasses the ALU: answer straight away.
            cnt_d       = '0;
            rsp_data_d  = '1;
            rsp_carry_d = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_data_d  = alu_out;
          rsp_carry_d = alu_carry;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Output mapping.
  always_comb begin
    alu_a     = alu_a_q;
    alu_b     = alu_b_q;
    alu_sel   = alu_sel_q;
    rsp_valid = rsp_valid_q;
    rsp_id    = rsp_id_q;
    rsp_data  = rsp_data_q;
    rsp_carry = rsp_carry_q;
    rsp_err   = rsp_err_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed testbench for alu_share_arbiter with a small behavioural ALU.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [4:0]  req0_sel;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [4:0]  req1_sel;
  logic [31:0] alu_a, alu_b;
  logic [4:0]  alu_sel;
  logic [31:0] alu_out;
  logic        alu_carry;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err, busy;
  logic [31:0] rsp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.MULDIV_CYCLES(4), .ALU_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .busy(busy)
  );

  // Behavioural ALU: add, mul, div (x/0 -> 0), xor otherwise.
  always_comb begin
    alu_out   = alu_a ^ alu_b;
    alu_carry = 1'b0;
    case (alu_sel)
      5'b00000: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      5'b00010: alu_out = alu_a * alu_b;
      5'b00011: alu_out = (alu_b != 0) ? alu_a / alu_b : 32'd0;
      default:  alu_out = alu_a ^ alu_b;
    endcase
  end

  // Present a request at a negedge and hold it until accepted; returns the
  // number of idle cycles waited (-1 on timeout). Ends at the negedge after
  // the transfer edge with valid dropped.
  task automatic issue(input int port, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sel, output int waited);
    waited = -1;
    if (port == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
    end
    for (int i = 0; i < 40; i++) begin
      #1;
      if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) begin
        waited = i;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  // Count posedges from the transfer edge until rsp_valid is seen.
  task automatic wait_rsp(output int n);
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_sel = 5'd0;
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd4; req1_sel = 5'd0;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if ({req0_ready, req1_ready, busy, rsp_valid, rsp_id, rsp_carry, rsp_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got r0=%b r1=%b busy=%b v=%b id=%b c=%b e=%b want all 0",
               req0_ready, req1_ready, busy, rsp_valid, rsp_id, rsp_carry, rsp_err);
    end
    checks++;
    if ({alu_a, alu_b, alu_sel, rsp_data} !== '0) begin
      errors++;
      $display("FAIL reset_data got a=%h b=%h sel=%h d=%h want 0", alu_a, alu_b, alu_sel, rsp_data);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_add();
    int w, n;
    issue(0, 32'd5, 32'd7, 5'b00000, w);
    checks++;
    if (w !== 0) begin errors++; $display("FAIL add_ready got wait=%0d want 0", w); end
    checks++;
    if (busy !== 1'b1 || alu_a !== 32'd5 || alu_b !== 32'd7 || alu_sel !== 5'd0) begin
      errors++;
      $display("FAIL add_exec got busy=%b a=%0d b=%0d sel=%0d want 1 5 7 0", busy, alu_a, alu_b, alu_sel);
    end
    wait_rsp(n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL add_latency got %0d want 2", n); end
    checks++;
    if (rsp_data !== 32'd12 || rsp_id !== 1'b0 || rsp_carry !== 1'b0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL add_rsp got d=%0d id=%b c=%b e=%b want 12 0 0 0", rsp_data, rsp_id, rsp_carry, rsp_err);
    end
    consume();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL add_consume got v=%b busy=%b want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_carry();
    int w, n;
    issue(1, 32'hFFFF_FFFF, 32'd1, 5'b00000, w);
    wait_rsp(n);
    checks++;
    if (n !== 2 || rsp_data !== 32'd0 || rsp_carry !== 1'b1 || rsp_id !== 1'b1) begin
      errors++;
      $display("FAIL carry_rsp got n=%0d d=%h c=%b id=%b want 2 0 1 1", n, rsp_data, rsp_carry, rsp_id);
    end
    consume();
  endtask

  task automatic test_multicycle_mul();
    int w, n;
    logic saw;
    saw = 1'b0;
    issue(0, 32'd6, 32'd7, 5'b00010, w);
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_sel = 5'd0;
    n = 1;
    #1;
    saw = req0_ready | req1_ready;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      #1;
      saw = saw | req0_ready | req1_ready;
      n++;
    end
    checks++;
    if (n !== 5) begin errors++; $display("FAIL mul_latency got %0d want 5", n); end
    checks++;
    if (rsp_data !== 32'd42 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL mul_rsp got d=%0d id=%b want 42 0", rsp_data, rsp_id);
    end
    checks++;
    if (saw !== 1'b0) begin errors++; $display("FAIL mul_no_ready got %b want 0", saw); end
    @(negedge clk);
    consume();
    issue(1, 32'd1, 32'd1, 5'b00000, w);
    wait_rsp(n);
    checks++;
    if (w !== 0 || rsp_data !== 32'd2 || rsp_id !== 1'b1) begin
      errors++;
      $display("FAIL mul_followup got w=%0d d=%0d id=%b want 0 2 1", w, rsp_data, rsp_id);
    end
    consume();
  endtask

  task automatic test_round_robin();
    int got;
    int cyc;
    logic [31:0] exp_d;
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd1; req0_sel = 5'd0;
    req1_valid = 1'b1; req1_a = 32'd200; req1_b = 32'd2; req1_sel = 5'd0;
    rsp_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        exp_d = (got % 2 == 0) ? 32'd101 : 32'd202;
        checks++;
        if (rsp_id !== 1'((got % 2)) || rsp_data !== exp_d) begin
          errors++;
          $display("FAIL rr_op%0d got id=%b d=%0d want id=%0d d=%0d", got, rsp_id, rsp_data, got % 2, exp_d);
        end
        got++;
      end
    end
    checks++;
    if (got !== 8) begin errors++; $display("FAIL rr_count got %0d want 8", got); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int w, n;
    logic bad;
    issue(0, 32'd3, 32'd4, 5'b00000, w);
    wait_rsp(n);
    req1_valid = 1'b1; req1_a = 32'd8; req1_b = 32'd8; req1_sel = 5'd0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd7 || rsp_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold got v=%b d=%0d id=%b r1=%b want 1 7 0 0", rsp_valid, rsp_data, rsp_id, req1_ready);
    end
    consume();
    issue(1, 32'd8, 32'd8, 5'b00000, w);
    wait_rsp(n);
    checks++;
    if (w !== 0 || n !== 2 || rsp_data !== 32'd16 || rsp_id !== 1'b1) begin
      errors++;
      $display("FAIL bp_next got w=%0d n=%0d d=%0d id=%b want 0 2 16 1", w, n, rsp_data, rsp_id);
    end
    consume();
  endtask

  task automatic test_reset_mid_div();
    int w, n;
    logic seen;
    issue(0, 32'd20, 32'd5, 5'b00011, w);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_a !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid got v=%b busy=%b a=%0d want 0 0 0", rsp_valid, busy, alu_a);
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | rsp_valid | busy;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_abandon got %b want 0", seen); end
    issue(0, 32'd20, 32'd5, 5'b00011, w);
    wait_rsp(n);
    checks++;
    if (n !== 5 || rsp_data !== 32'd4) begin
      errors++;
      $display("FAIL div_after_rst got n=%0d d=%0d want 5 4", n, rsp_data);
    end
    consume();
  endtask

  task automatic test_div0();
    int w, n;
    issue(1, 32'd9, 32'd0, 5'b00011, w);
    wait_rsp(n);
`ifdef ALU_ARB_DIV0_GUARD_EN
    checks++;
    if (n !== 1 || rsp_data !== 32'hFFFF_FFFF || rsp_err !== 1'b1 || rsp_carry !== 1'b0) begin
      errors++;
      $display("FAIL div0 got n=%0d d=%h e=%b c=%b want 1 ffffffff 1 0", n, rsp_data, rsp_err, rsp_carry);
    end
`else
    checks++;
    if (n !== 5 || rsp_data !== 32'd0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL div0 got n=%0d d=%h e=%b want 5 0 0", n, rsp_data, rsp_err);
    end
`endif
    checks++;
    if (alu_a !== 32'd9 || alu_b !== 32'd0 || alu_sel !== 5'b00011) begin
      errors++;
      $display("FAIL div0_alu got a=%0d b=%0d sel=%b want 9 0 00011", alu_a, alu_b, alu_sel);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_carry();
    test_multicycle_mul();
    test_round_robin();
    test_backpressure();
    test_reset_mid_div();
    test_div0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
